// File: rtl/sn65lv1224_frame_checker_if.sv
`default_nettype none
// ============================================================================
// Module  : sn65lv1224_frame_checker_if
// Brief   : Deserializer data/lock inputs and checker status outputs.
// Revision: 1.0
// ============================================================================
interface sn65lv1224_frame_checker_if #(
  parameter int COUNT_W = 16
);
  logic               lock_active_low;
  logic [9:0]         data_in;
  logic               aligned;
  logic               frame_start;
  logic [9:0]         payload;
  logic               payload_valid;
  logic               word_error;
  logic [COUNT_W-1:0] error_count;
  logic [COUNT_W-1:0] good_frame_count;
  logic [1:0]         state;

  modport master (
    output lock_active_low, data_in,
    input  aligned, frame_start, payload, payload_valid, word_error,
    input  error_count, good_frame_count, state
  );

  modport slave (
    input  lock_active_low, data_in,
    output aligned, frame_start, payload, payload_valid, word_error,
    output error_count, good_frame_count, state
  );
endinterface
`default_nettype wire

// File: rtl/sn65lv1224_frame_checker.sv
`default_nettype none
// ============================================================================
// Module  : sn65lv1224_frame_checker
// Brief   : Aligns to and checks the 32-word SN65LV1023 test frame.
// Revision: 1.0
// ============================================================================
module sn65lv1224_frame_checker #(
  parameter int LOCK_FRAMES   = 2,
  parameter int UNLOCK_FRAMES = 4,
  parameter int COUNT_W       = 16
) (
  input wire                        clock,
  input wire                        reset_active_low,
  sn65lv1224_frame_checker_if.slave bus
);

  localparam int GF_W = $clog2(LOCK_FRAMES + 1);
  localparam int BF_W = $clog2(UNLOCK_FRAMES + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         w0_q, w0_d, w1_q, w1_d;
  logic [4:0]         index_q, index_d;
  logic [GF_W-1:0]    good_frames_q, good_frames_d;
  logic [BF_W-1:0]    bad_frames_q, bad_frames_d;
  logic               flag_q, flag_d;
  logic               aligned_q, aligned_d;
  logic               frame_start_q, frame_start_d;
  logic [9:0]         payload_q, payload_d;
  logic               payload_valid_q, payload_valid_d;
  logic               word_error_q, word_error_d;
  logic [COUNT_W-1:0] error_count_q, error_count_d;
  logic [COUNT_W-1:0] good_frame_count_q, good_frame_count_d;

  logic               mismatch;
  logic [GF_W-1:0]    good_frames_inc;
  logic [BF_W-1:0]    bad_frames_inc;

  // Index 12 carries the random payload and has no expected value.
  function automatic logic [9:0] expected_word(input logic [4:0] idx);
    if (idx == 5'd0 || idx >= 5'd13) begin
      return 10'h3FF;
    end else if (idx <= 5'd10) begin
      return 10'h3FF >> idx;
    end else begin
      return 10'h155;
    end
  endfunction

  assign mismatch        = (index_q != 5'd12) && (w0_q != expected_word(index_q));
  assign good_frames_inc = good_frames_q + GF_W'(1);
  assign bad_frames_inc  = bad_frames_q + BF_W'(1);

  always_comb begin
    w0_d               = bus.data_in;
    w1_d               = w0_q;
    state_d            = state_q;
    index_d            = index_q + 5'd1;
    good_frames_d      = good_frames_q;
    bad_frames_d       = bad_frames_q;
    flag_d             = flag_q;
    frame_start_d      = 1'b0;
    payload_d          = payload_q;
    payload_valid_d    = 1'b0;
    word_error_d       = 1'b0;
    error_count_d      = error_count_q;
    good_frame_count_d = good_frame_count_q;

    // Deserializer unlock overrides every other event this cycle.
    if (bus.lock_active_low) begin
      state_d       = HUNT;
      good_frames_d = '0;
      bad_frames_d  = '0;
      flag_d        = 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          if (w1_q == 10'h3FF && w0_q == 10'h1FF) begin
            state_d       = VERIFY;
            index_d       = 5'd2;
            good_frames_d = '0;
            flag_d        = 1'b0;
          end
        end

        VERIFY: begin
          if (mismatch) begin
            word_error_d = 1'b1;
            state_d      = HUNT;
          end else if (index_q == 5'd31) begin
            good_frames_d = good_frames_inc;
            if (good_frames_inc == GF_W'(LOCK_FRAMES)) begin
              state_d      = LOCKED;
              bad_frames_d = '0;
            end
          end
        end

        LOCKED: begin
          frame_start_d = (index_q == 5'd0);
          if (index_q == 5'd12) begin
            payload_d       = w0_q;
            payload_valid_d = 1'b1;
          end
          if (mismatch) begin
            word_error_d = 1'b1;
            if (error_count_q != '1) begin
              error_count_d = error_count_q + COUNT_W'(1);
            end
          end
          // A mismatch on the last word still belongs to this frame's verdict.
          if (index_q == 5'd31) begin
            if (flag_q || mismatch) begin
              bad_frames_d = bad_frames_inc;
              if (bad_frames_inc == BF_W'(UNLOCK_FRAMES)) begin
                state_d = HUNT;
              end
            end else begin
              bad_frames_d = '0;
              if (good_frame_count_q != '1) begin
                good_frame_count_d = good_frame_count_q + COUNT_W'(1);
              end
            end
            flag_d = 1'b0;
          end else if (mismatch) begin
            flag_d = 1'b1;
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end

    aligned_d = (state_d == LOCKED);
  end

  always_ff @(posedge clock or negedge reset_active_low) begin
    if (!reset_active_low) begin
      state_q            <= HUNT;
      w0_q               <= '0;
      w1_q               <= '0;
      index_q            <= '0;
      good_frames_q      <= '0;
      bad_frames_q       <= '0;
      flag_q             <= 1'b0;
      aligned_q          <= 1'b0;
      frame_start_q      <= 1'b0;
      payload_q          <= '0;
      payload_valid_q    <= 1'b0;
      word_error_q       <= 1'b0;
      error_count_q      <= '0;
      good_frame_count_q <= '0;
    end else begin
      state_q            <= state_d;
      w0_q               <= w0_d;
      w1_q               <= w1_d;
      index_q            <= index_d;
      good_frames_q      <= good_frames_d;
      bad_frames_q       <= bad_frames_d;
      flag_q             <= flag_d;
      aligned_q          <= aligned_d;
      frame_start_q      <= frame_start_d;
      payload_q          <= payload_d;
      payload_valid_q    <= payload_valid_d;
      word_error_q       <= word_error_d;
      error_count_q      <= error_count_d;
      good_frame_count_q <= good_frame_count_d;
    end
  end

  assign bus.aligned          = aligned_q;
  assign bus.frame_start      = frame_start_q;
  assign bus.payload          = payload_q;
  assign bus.payload_valid    = payload_valid_q;
  assign bus.word_error       = word_error_q;
  assign bus.error_count      = error_count_q;
  assign bus.good_frame_count = good_frame_count_q;
  assign bus.state            = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sn65lv1224_frame_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_sn65lv1224_frame_checker
// Brief   : Directed frame stimulus with a frame-level reference model.
// Revision: 1.0
// ============================================================================
module tb_sn65lv1224_frame_checker;

  localparam int LOCK_FRAMES   = 2;
  localparam int UNLOCK_FRAMES = 4;

  logic       clock = 1'b0;
  logic       reset_active_low = 1'b0;
  logic       lock_n = 1'b0;
  logic [9:0] din = '0;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;
  int we_cnt = 0;
  int pv_cnt = 0;

  logic [9:0] exp_frame [32];

  sn65lv1224_frame_checker_if #(.COUNT_W(16)) bus ();
  sn65lv1224_frame_checker_if #(.COUNT_W(8))  bus8 ();

  assign bus.lock_active_low  = lock_n;
  assign bus.data_in          = din;
  assign bus8.lock_active_low = lock_n;
  assign bus8.data_in         = din;

  sn65lv1224_frame_checker #(
    .LOCK_FRAMES(LOCK_FRAMES), .UNLOCK_FRAMES(UNLOCK_FRAMES), .COUNT_W(16)
  ) dut (
    .clock(clock), .reset_active_low(reset_active_low), .bus(bus)
  );

  // Narrow-counter copy on the same stream so saturation is reachable quickly.
  sn65lv1224_frame_checker #(
    .LOCK_FRAMES(LOCK_FRAMES), .UNLOCK_FRAMES(UNLOCK_FRAMES), .COUNT_W(8)
  ) dut8 (
    .clock(clock), .reset_active_low(reset_active_low), .bus(bus8)
  );

  always #5 clock = ~clock;

  // Reference model: mode 0/1/2 = hunting/verifying/locked, m_pos = frame
  // position of the most recent registered word.
  int         m_mode = 0, m_pos = 0, m_good_run = 0, m_bad_run = 0, m_nxt = 0;
  bit         m_dirty = 0, m_fs = 0, m_pv = 0, m_we = 0, m_word_bad = 0;
  logic [9:0] m_h0 = '0, m_h1 = '0, m_payload = '0;
  longint     m_errs = 0, m_goods = 0;

  always @(posedge clock or negedge reset_active_low) begin
    if (!reset_active_low) begin
      m_mode = 0; m_pos = 0; m_good_run = 0; m_bad_run = 0; m_dirty = 0;
      m_fs = 0; m_pv = 0; m_we = 0; m_h0 = '0; m_h1 = '0; m_payload = '0;
      m_errs = 0; m_goods = 0;
    end else begin
      m_fs = 0; m_pv = 0; m_we = 0;
      m_word_bad = (m_pos != 12) && (m_h0 != exp_frame[m_pos]);
      m_nxt = (m_pos + 1) % 32;
      if (lock_n) begin
        m_mode = 0; m_good_run = 0; m_bad_run = 0; m_dirty = 0;
      end else if (m_mode == 0) begin
        if (m_h1 == 10'h3FF && m_h0 == 10'h1FF) begin
          m_mode = 1; m_nxt = 2; m_good_run = 0; m_dirty = 0;
        end
      end else if (m_mode == 1) begin
        if (m_word_bad) begin
          m_we = 1; m_mode = 0;
        end else if (m_pos == 31) begin
          m_good_run++;
          if (m_good_run == LOCK_FRAMES) begin
            m_mode = 2; m_bad_run = 0;
          end
        end
      end else begin
        m_fs = (m_pos == 0);
        if (m_pos == 12) begin
          m_payload = m_h0; m_pv = 1;
        end
        if (m_word_bad) begin
          m_we = 1; m_errs++; m_dirty = 1;
        end
        if (m_pos == 31) begin
          if (m_dirty) begin
            m_bad_run++;
            if (m_bad_run == UNLOCK_FRAMES) m_mode = 0;
          end else begin
            m_bad_run = 0; m_goods++;
          end
          m_dirty = 0;
        end
      end
      m_pos = m_nxt;
      m_h1  = m_h0;
      m_h0  = din;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint lim);
    return (v > lim) ? lim : v;
  endfunction

  always @(negedge clock) begin
    if (cmp_en) begin
      check("state",             bus.state,            m_mode);
      check("aligned",           bus.aligned,          (m_mode == 2) ? 1 : 0);
      check("frame_start",       bus.frame_start,      m_fs);
      check("payload_valid",     bus.payload_valid,    m_pv);
      check("payload",           bus.payload,          m_payload);
      check("word_error",        bus.word_error,       m_we);
      check("error_count",       bus.error_count,      sat(m_errs, 65535));
      check("good_frame_count",  bus.good_frame_count, sat(m_goods, 65535));
      check("state8",            bus8.state,           m_mode);
      check("error_count8",      bus8.error_count,     sat(m_errs, 255));
      check("good_frame_count8", bus8.good_frame_count, sat(m_goods, 255));
    end
    if (bus.word_error)    we_cnt++;
    if (bus.payload_valid) pv_cnt++;
  end

  task automatic send(input logic [9:0] w, input logic l);
    @(posedge clock);
    #1;
    din    = w;
    lock_n = l;
  endtask

  function automatic logic [9:0] frame_word(input int i, input logic [9:0] pl);
    return (i == 12) ? pl : exp_frame[i];
  endfunction

  task automatic send_frame(input logic [9:0] pl, input int bad_idx, input bit all_bad);
    logic [9:0] w;
    for (int i = 0; i < 32; i++) begin
      w = frame_word(i, pl);
      if (all_bad || i == bad_idx) w = w ^ 10'h001;
      send(w, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_frame[i] = 10'h3FF;
    for (int i = 1; i <= 10; i++) exp_frame[i] = 10'((1 << (10 - i)) - 1);
    exp_frame[11] = 10'h155;
    exp_frame[12] = 10'h000;

    cmp_en = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("lit_rst_state",   bus.state, 0);
    check("lit_rst_aligned", bus.aligned, 0);
    check("lit_rst_errs",    bus.error_count, 0);
    reset_active_low = 1'b1;

    // Acquisition: partial first frame counts, lock after the second.
    send_frame(10'h000, -1, 0);
    check("lit_f1_state", bus.state, 1);
    send_frame(10'h000, -1, 0);
    check("lit_f2_state", bus.state, 1);
    send_frame(10'h000, -1, 0);
    check("lit_f3_state",   bus.state, 2);
    check("lit_f3_aligned", bus.aligned, 1);
    check("lit_f3_errs",    bus.error_count, 0);

    send_frame(10'h2A5, -1, 0);
    check("lit_f4_payload", bus.payload, 10'h2A5);
    check("lit_f4_goods",   bus.good_frame_count, 1);
    send_frame(10'h15A, -1, 0);
    check("lit_f5_payload", bus.payload, 10'h15A);
    check("lit_f5_goods",   bus.good_frame_count, 2);
    check("lit_f5_pv_cnt",  pv_cnt, 3);
    check("lit_f5_we_cnt",  we_cnt, 0);

    // Three bad frames then clean: stays locked.
    repeat (3) send_frame(10'h15A, 5, 0);
    repeat (2) send_frame(10'h15A, -1, 0);
    check("lit_f10_errs",    bus.error_count, 3);
    check("lit_f10_aligned", bus.aligned, 1);
    check("lit_f10_we_cnt",  we_cnt, 3);
    check("lit_f10_goods",   bus.good_frame_count, 4);

    // Four bad frames: lock lost, immediate resync on the next frame.
    repeat (4) send_frame(10'h15A, 5, 0);
    send_frame(10'h15A, -1, 0);
    check("lit_f15_state",   bus.state, 1);
    check("lit_f15_aligned", bus.aligned, 0);
    check("lit_f15_errs",    bus.error_count, 7);
    send_frame(10'h15A, -1, 0);
    send_frame(10'h15A, -1, 0);
    check("lit_f17_state",  bus.state, 2);
    check("lit_f17_we_cnt", we_cnt, 7);

    // Deserializer unlock pulse mid-frame.
    for (int i = 0; i < 32; i++) begin
      send(frame_word(i, 10'h15A), (i == 20) ? 1'b1 : 1'b0);
      if (i == 23) begin
        check("lit_unlock_state", bus.state, 0);
        check("lit_unlock_errs",  bus.error_count, 7);
      end
    end
    check("lit_unlock_we_cnt", we_cnt, 7);
    send_frame(10'h15A, -1, 0);
    check("lit_f19_state", bus.state, 1);

    // Asynchronous reset mid-VERIFY.
    for (int i = 0; i < 32; i++) begin
      send(frame_word(i, 10'h15A), 1'b0);
      if (i == 4) begin
        #1 reset_active_low = 1'b0;
        #1;
        check("lit_arst_state",   bus.state, 0);
        check("lit_arst_errs",    bus.error_count, 0);
        check("lit_arst_payload", bus.payload, 0);
        check("lit_arst_goods",   bus.good_frame_count, 0);
      end
      if (i == 7) reset_active_low = 1'b1;
    end

    // Relock, then heavy error injection to saturate the narrow counters.
    repeat (3) send_frame(10'h0F0, -1, 0);
    repeat (3) begin
      repeat (3) send_frame(10'h0F0, -1, 1);
      send_frame(10'h0F0, -1, 0);
    end
    send_frame(10'h0F0, -1, 0);
    check("lit_sat_errs",    bus.error_count, 279);
    check("lit_sat_errs8",   bus8.error_count, 255);
    check("lit_sat_goods",   bus.good_frame_count, 4);
    check("lit_sat_aligned", bus.aligned, 1);
    repeat (2) begin
      repeat (3) send_frame(10'h0F0, -1, 1);
      send_frame(10'h0F0, -1, 0);
    end
    send_frame(10'h0F0, -1, 0);
    check("lit_hold_errs",  bus.error_count, 465);
    check("lit_hold_errs8", bus8.error_count, 255);
    check("lit_hold_goods", bus.good_frame_count, 7);

    repeat (4) @(posedge clock);
    @(negedge clock);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
